// File: rtl/ita_requant_stage.sv
// ita_requant_stage: 2-cycle requantizer (acc*eps, round, >>>sh, +add, saturate) with valid/ready on both sides at full throughput.
// Defining ITA_REQUANT_SAT_CNT_EN adds sat_count_o/sat_clear_i (clipped-lane counter); the default build omits them.
module ita_requant_stage #(
  parameter int N                = 16,
  parameter int WO               = 26,
  parameter int WI               = 8,
  parameter int EMS              = 8,
  parameter int N_REQUANT_CONSTS = 6
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [N*WO-1:0]                 data_i,
  input  logic [2:0]                      step_i,
  input  logic [N_REQUANT_CONSTS*EMS-1:0] eps_mult_i,
  input  logic [N_REQUANT_CONSTS*EMS-1:0] right_shift_i,
  input  logic [N_REQUANT_CONSTS*WI-1:0]  add_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [N*WI-1:0]                 data_o
`ifdef ITA_REQUANT_SAT_CNT_EN
  ,
  output logic [15:0]                     sat_count_o,
  input  logic                            sat_clear_i
`endif
);

  localparam int PW = WO + EMS + 1;
  localparam int XW = PW + 2;
  localparam int VW = XW + 1;
  localparam logic signed [VW-1:0] SAT_MAX = VW'((1 <<< (WI - 1)) - 1);
  localparam logic signed [VW-1:0] SAT_MIN = VW'(-(1 <<< (WI - 1)));

  // Rounded arithmetic shift plus offset, unclipped; XW/VW leave headroom so nothing wraps.
  function automatic logic signed [VW-1:0] requant_lane(
    input logic signed [PW-1:0]  prod,
    input logic        [EMS-1:0] sh,
    input logic signed [WI-1:0]  add
  );
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] r;
    x = XW'(prod);
    if (sh >= EMS'(PW)) begin
      r = {XW{prod[PW-1]}};
    end else if (sh == '0) begin
      r = x;
    end else begin
      r = (x + (XW'(1) <<< (sh - EMS'(1)))) >>> sh;
    end
    return VW'(r) + VW'(add);
  endfunction

  function automatic logic [WI-1:0] clip_lane(input logic signed [VW-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[WI-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[WI-1:0];
    end
    return v[WI-1:0];
  endfunction

  logic                 w_step_ok;
  logic [EMS-1:0]       w_eps;
  logic [EMS-1:0]       w_sh;
  logic signed [WI-1:0] w_add;
  logic signed [PW-1:0] w_prod [N];
  logic                 w_s1_acc;
  logic                 w_s2_adv;
  logic signed [VW-1:0] w_s2_v [N];
  logic [N*WI-1:0]      w_s2_dat;

  logic                 r_s1_vld;
  logic signed [PW-1:0] r_s1_prod [N];
  logic [EMS-1:0]       r_s1_sh;
  logic signed [WI-1:0] r_s1_add;
  logic                 r_s2_vld;
  logic [N*WI-1:0]      r_s2_dat;

  assign w_s2_adv = !r_s2_vld || ready_i;
  assign ready_o  = !r_s1_vld || w_s2_adv;
  assign w_s1_acc = valid_i && ready_o;
  assign valid_o  = r_s2_vld;
  assign data_o   = r_s2_dat;

  // An out-of-range step selects eps=0, sh=0, add=0, which drives every lane to zero.
  always_comb begin
    w_step_ok = (int'(step_i) < N_REQUANT_CONSTS);
    w_eps     = '0;
    w_sh      = '0;
    w_add     = '0;
    if (w_step_ok) begin
      w_eps = eps_mult_i[int'(step_i)*EMS +: EMS];
      w_sh  = right_shift_i[int'(step_i)*EMS +: EMS];
      w_add = add_i[int'(step_i)*WI +: WI];
    end
    for (int l = 0; l < N; l++) begin
      w_prod[l] = PW'($signed(data_i[l*WO +: WO])) * $signed({{(PW-EMS){1'b0}}, w_eps});
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_vld <= 1'b0;
      r_s1_sh  <= '0;
      r_s1_add <= '0;
      for (int l = 0; l < N; l++) begin
        r_s1_prod[l] <= '0;
      end
    end else if (w_s1_acc) begin
      r_s1_vld <= 1'b1;
      r_s1_sh  <= w_sh;
      r_s1_add <= w_add;
      for (int l = 0; l < N; l++) begin
        r_s1_prod[l] <= w_prod[l];
      end
    end else if (w_s2_adv) begin
      r_s1_vld <= 1'b0;
    end
  end

  always_comb begin
    w_s2_dat = '0;
    for (int l = 0; l < N; l++) begin
      w_s2_v[l]               = requant_lane(r_s1_prod[l], r_s1_sh, r_s1_add);
      w_s2_dat[l*WI +: WI]    = clip_lane(w_s2_v[l]);
    end
  end

  // S2 holds its beat until the downstream handshake, keeping valid_o/data_o stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s2_vld <= 1'b0;
      r_s2_dat <= '0;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_dat <= w_s2_dat;
      end
    end
  end

`ifdef ITA_REQUANT_SAT_CNT_EN
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] w_s2_nsat;
  logic [16:0]   w_sat_sum;
  logic [CW-1:0] r_s2_nsat;
  logic [15:0]   r_sat_cnt;

  always_comb begin
    w_s2_nsat = '0;
    for (int l = 0; l < N; l++) begin
      if ((w_s2_v[l] > SAT_MAX) || (w_s2_v[l] < SAT_MIN)) begin
        w_s2_nsat = w_s2_nsat + CW'(1);
      end
    end
  end

  assign w_sat_sum   = {1'b0, r_sat_cnt} + 17'(r_s2_nsat);
  assign sat_count_o = r_sat_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s2_nsat <= '0;
      r_sat_cnt <= '0;
    end else begin
      if (w_s2_adv && r_s1_vld) begin
        r_s2_nsat <= w_s2_nsat;
      end
      if (sat_clear_i) begin
        r_sat_cnt <= '0;
      end else if (r_s2_vld && ready_i) begin
        r_sat_cnt <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
      end
    end
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_s1_acc) begin
      assert (w_step_ok)
        else $warning("ita_requant_stage: step_i=%0d out of range, lanes forced to zero", step_i);
    end
  end
`endif

endmodule

// File: tb/tb_ita_requant_stage.sv
// Randomized + directed bench for ita_requant_stage against an arithmetic reference model and beat scoreboard.
// The saturation-counter scenario is compiled only when ITA_REQUANT_SAT_CNT_EN is defined.
module tb_ita_requant_stage;
  localparam int N   = 16;
  localparam int WO  = 26;
  localparam int WI  = 8;
  localparam int EMS = 8;
  localparam int NC  = 6;

  typedef logic [N*WI-1:0] beat_t;

  logic              clk_i;
  logic              rst_i;
  logic              valid_i;
  logic              ready_o;
  logic [N*WO-1:0]   data_i;
  logic [2:0]        step_i;
  logic [NC*EMS-1:0] eps_mult_i;
  logic [NC*EMS-1:0] right_shift_i;
  logic [NC*WI-1:0]  add_i;
  logic              valid_o;
  logic              ready_i;
  logic [N*WI-1:0]   data_o;
`ifdef ITA_REQUANT_SAT_CNT_EN
  logic [15:0]       sat_count_o;
  logic              sat_clear_i;
`endif

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  beat_t got_q[$];

  ita_requant_stage #(.N(N), .WO(WO), .WI(WI), .EMS(EMS), .N_REQUANT_CONSTS(NC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .step_i(step_i), .eps_mult_i(eps_mult_i), .right_shift_i(right_shift_i), .add_i(add_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
`ifdef ITA_REQUANT_SAT_CNT_EN
    , .sat_count_o(sat_count_o), .sat_clear_i(sat_clear_i)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Reference: floor((acc*eps + 2^(sh-1)) / 2^sh) + add, clipped to the signed 8-bit range.
  function automatic longint ref_lane(longint acc, longint eps, longint sh, longint add);
    longint p, num, den, r, v;
    p = acc * eps;
    if (sh >= 35) begin
      r = (p < 0) ? -1 : 0;
    end else if (sh == 0) begin
      r = p;
    end else begin
      num = p + (longint'(1) << (sh - 1));
      den = longint'(1) << sh;
      r   = num / den;
      if ((num % den != 0) && (num < 0)) r = r - 1;
    end
    v = r + add;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  function automatic beat_t ref_beat();
    beat_t b;
    int    s;
    b = '0;
    s = int'(step_i);
    if (s < NC) begin
      for (int l = 0; l < N; l++) begin
        b[l*WI +: WI] = WI'(ref_lane(longint'($signed(data_i[l*WO +: WO])),
                                     longint'(eps_mult_i[s*EMS +: EMS]),
                                     longint'(right_shift_i[s*EMS +: EMS]),
                                     longint'($signed(add_i[s*WI +: WI]))));
      end
    end
    return b;
  endfunction

  // Records every accepted input (as its expected result) and every delivered output beat.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (valid_i && ready_o) exp_q.push_back(ref_beat());
      if (valid_o && ready_i) got_q.push_back(data_o);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_const(input int s, input int eps, input int sh, input int add);
    eps_mult_i[s*EMS +: EMS]    = EMS'(eps);
    right_shift_i[s*EMS +: EMS] = EMS'(sh);
    add_i[s*WI +: WI]           = WI'(add);
  endtask

  task automatic rand_lanes();
    for (int l = 0; l < N; l++) data_i[l*WO +: WO] = WO'($urandom);
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() == exp_q.size()) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    repeat (3) tick();
    checks++;
    if (valid_o !== 1'b0 || data_o !== '0) begin
      errors++; $display("FAIL reset_state: valid_o=%b data_o=%h, want 0/0", valid_o, data_o);
    end
    rst_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: ready_o=%b, want 1", ready_o);
    end
    set_const(0, 5, 2, 3);
    step_i = 3'd0; ready_i = 1'b0; valid_i = 1'b1;
    rand_lanes(); tick();
    rand_lanes(); tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_prefill: valid_o=%b ready_o=%b, want 1/0", valid_o, ready_o);
    end
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid_o !== 1'b0 || data_o !== '0) begin
        errors++; $display("FAIL reset_mid: cycle %0d valid_o=%b data_o=%h, want 0/0", i, valid_o, data_o);
      end
    end
    rst_i = 1'b0; ready_i = 1'b1;
    exp_q.delete(); got_q.delete();
    repeat (5) tick();
    checks++;
    if (got_q.size() != 0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_stale: %0d beats after reset, valid_o=%b, want 0/0", got_q.size(), valid_o);
    end
    got_q.delete();
  endtask

  task automatic test_directed();
    int    t_acc [10];
    int    t_eps [10];
    int    t_sh  [10];
    int    t_add [10];
    int    t_exp [10];
    beat_t e, g;
    t_acc = '{1000, -1000, 1 << 20, -(1 << 20), -1000, 1000, 48, -48, 33554431, 127};
    t_eps = '{3,    3,     255,     255,        3,     3,    1,  1,   255,      1};
    t_sh  = '{5,    5,     8,       8,          40,    40,   5,  5,   30,       0};
    t_add = '{-4,   0,     0,       0,          5,     5,    0,  0,   0,        127};
    t_exp = '{90,   -94,   127,     -128,       4,     5,    2,  -1,  8,        127};
    ready_i = 1'b1; step_i = 3'd0;
    for (int i = 0; i < 10; i++) begin
      set_const(0, t_eps[i], t_sh[i], t_add[i]);
      for (int l = 0; l < N; l++) data_i[l*WO +: WO] = WO'(t_acc[i]);
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      checks++;
      if (valid_o !== 1'b0) begin
        errors++; $display("FAIL latency_early: case %0d valid_o=%b at t+1, want 0", i, valid_o);
      end
      tick();
      checks++;
      if (valid_o !== 1'b1 || data_o[WI-1:0] !== WI'(t_exp[i]) || data_o[N*WI-1 -: WI] !== WI'(t_exp[i])) begin
        errors++;
        $display("FAIL directed: case %0d valid_o=%b lane0=%0d lane15=%0d, want 1/%0d", i, valid_o,
                 $signed(data_o[WI-1:0]), $signed(data_o[N*WI-1 -: WI]), t_exp[i]);
      end
    end
    tick();
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL directed_sb: got %h want %h", g, e); end
    end
  endtask

  task automatic test_random();
    bit    ok;
    beat_t e, g;
    for (int s = 0; s < NC; s++) set_const(s, $urandom_range(0, 255), $urandom_range(0, 40), int'($urandom_range(0, 255)) - 128);
    for (int c = 0; c < 80; c++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      step_i  = 3'($urandom_range(0, NC - 1));
      rand_lanes();
      if ($urandom_range(0, 3) == 0) begin
        set_const($urandom_range(0, NC - 1), $urandom_range(0, 255), $urandom_range(0, 40), int'($urandom_range(0, 255)) - 128);
      end
      tick();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    wait_drain(20, ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++; $display("FAIL random_drain: got %0d beats want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL random_beat: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    int    pat [4];
    int    sent, inflight, seen;
    bit    stalled, exp_rdy, ok;
    beat_t prev, e, g;
    pat = '{1, 0, 0, 1};
    sent = 0; seen = 0; stalled = 1'b0; prev = '0;
    for (int s = 0; s < NC; s++) set_const(s, $urandom_range(1, 255), $urandom_range(0, 12), int'($urandom_range(0, 255)) - 128);
    for (int c = 0; c < 80 && (sent < 10 || exp_q.size() != got_q.size()); c++) begin
      if (stalled) begin
        checks++;
        if (valid_o !== 1'b1 || data_o !== prev) begin
          errors++; $display("FAIL stall_hold: valid_o=%b data_o=%h, want 1/%h", valid_o, data_o, prev);
        end
      end
      valid_i = (sent < 10);
      step_i  = 3'($urandom_range(0, NC - 1));
      rand_lanes();
      ready_i = pat[c % 4][0];
      #1;
      inflight = exp_q.size() - got_q.size();
      exp_rdy  = !(inflight == 2 && !ready_i);
      checks++;
      if (ready_o !== exp_rdy) begin
        errors++; $display("FAIL b2b_ready: cycle %0d ready_o=%b want %b (inflight %0d)", c, ready_o, exp_rdy, inflight);
      end
      if (valid_i && ready_o) sent++;
      stalled = valid_o && !ready_i;
      prev    = data_o;
      tick();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    wait_drain(10, ok);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); seen++;
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_order: beat %0d got %h want %h", seen, g, e); end
    end
    checks++;
    if (!ok || seen != 10) begin
      errors++; $display("FAIL b2b_count: delivered %0d beats, want 10", seen);
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_step_switch();
    int    steps [4];
    int    seen;
    bit    ok;
    beat_t e, g;
    steps = '{0, 3, 5, 6};
    seen = 0; g = '1;
    set_const(0, 3, 5, -4); set_const(3, 7, 3, 1); set_const(5, 200, 10, -2);
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step_i  = 3'(steps[k]);
      valid_i = 1'b1;
      rand_lanes();
      if (k > 0) begin
        eps_mult_i[steps[k-1]*EMS +: EMS] = eps_mult_i[steps[k-1]*EMS +: EMS] + 8'd37;
      end
      tick();
    end
    valid_i = 1'b0;
    eps_mult_i[5*EMS +: EMS] = eps_mult_i[5*EMS +: EMS] + 8'd37;
    wait_drain(10, ok);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); seen++;
      checks++;
      if (g !== e) begin errors++; $display("FAIL step_switch: beat %0d got %h want %h", seen, g, e); end
    end
    checks++;
    if (!ok || seen != 4 || g !== '0) begin
      errors++; $display("FAIL step_invalid: %0d beats, last %h, want 4 beats ending in 0", seen, g);
    end
    exp_q.delete(); got_q.delete();
  endtask

`ifdef ITA_REQUANT_SAT_CNT_EN
  task automatic test_sat_counter();
    set_const(0, 1, 0, 0);
    step_i = 3'd0; ready_i = 1'b1; valid_i = 1'b0;
    sat_clear_i = 1'b1; tick(); sat_clear_i = 1'b0;
    checks++;
    if (sat_count_o !== 16'd0) begin errors++; $display("FAIL sat_init: %0d want 0", sat_count_o); end
    for (int l = 0; l < N; l++) data_i[l*WO +: WO] = WO'((l < 3) ? ((l == 1) ? -300 : 200) : 5);
    valid_i = 1'b1;
    repeat (4) tick();
    valid_i = 1'b0;
    repeat (4) tick();
    checks++;
    if (sat_count_o !== 16'd12) begin errors++; $display("FAIL sat_count: %0d want 12", sat_count_o); end
    valid_i = 1'b1; tick();
    valid_i = 1'b0; tick();
    sat_clear_i = 1'b1;
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL sat_clear_beat: valid_o=%b want 1", valid_o); end
    tick();
    sat_clear_i = 1'b0;
    checks++;
    if (sat_count_o !== 16'd0) begin errors++; $display("FAIL sat_clear: %0d want 0", sat_count_o); end
    for (int l = 0; l < N; l++) data_i[l*WO +: WO] = WO'(1000);
    valid_i = 1'b1;
    repeat (4100) tick();
    valid_i = 1'b0;
    repeat (4) tick();
    checks++;
    if (sat_count_o !== 16'hFFFF) begin errors++; $display("FAIL sat_max: %h want ffff", sat_count_o); end
    exp_q.delete(); got_q.delete();
  endtask
`endif

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; data_i = '0; step_i = '0;
    eps_mult_i = '0; right_shift_i = '0; add_i = '0;
`ifdef ITA_REQUANT_SAT_CNT_EN
    sat_clear_i = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_step_switch();
`ifdef ITA_REQUANT_SAT_CNT_EN
    test_sat_counter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
